bitslip_align_ctrl: RTL and testbench

BITSLIP_ALIGN_CTRL -- requirements
Module: bitslip_align_ctrl

---
 rtl/bitslip_align_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bitslip_align_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitslip_align_ctrl.sv
// rtl/bitslip_align_ctrl.sv - word-alignment controller issuing bitslip pulses until the frame lane matches PATTERN
module bitslip_align_ctrl #(
    parameter logic [7:0] PATTERN       = 8'hF0,
    parameter int         MATCH_COUNT   = 16,
    parameter int         SETTLE_CYCLES = 3,
    parameter int         MAX_SLIPS     = 8,
    parameter int         LOSS_THRESH   = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       en,
    input  logic       realign,
    input  logic [7:0] frame_i,
    output logic       bitslip_o,
    output logic       locked_o,
    output logic       error_o,
    output logic [3:0] slip_cnt_o
);

    typedef enum logic [2:0] {IDLE, CHECK, SLIP, SETTLE, LOCKED, FAIL} state_t;

    localparam logic [7:0] MATCH_LAST  = 8'(MATCH_COUNT - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LOSS_LAST   = 4'(LOSS_THRESH - 1);
    localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

    state_t     state_q, state_d;
    logic [7:0] match_q, match_d;
    logic [3:0] settle_q, settle_d;
    logic [3:0] loss_q, loss_d;
    logic [3:0] slip_q, slip_d;
    logic       bitslip_q, bitslip_d;
    logic       locked_q, locked_d;
    logic       error_q, error_d;

    logic hit;
    assign hit = (frame_i == PATTERN);

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        settle_d  = settle_q;
        loss_d    = loss_q;
        slip_d    = slip_q;
        bitslip_d = 1'b0;
        locked_d  = locked_q;
        error_d   = error_q;

        if (!en) begin
            // slip_cnt is deliberately kept so software can read it after an abort
            state_d  = IDLE;
            match_d  = '0;
            settle_d = '0;
            loss_d   = '0;
            locked_d = 1'b0;
            error_d  = 1'b0;
        end else if (realign && (state_q == LOCKED || state_q == FAIL)) begin
            state_d  = CHECK;
            match_d  = '0;
            settle_d = '0;
            loss_d   = '0;
            slip_d   = '0;
            locked_d = 1'b0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = CHECK;
                    match_d  = '0;
                    settle_d = '0;
                    loss_d   = '0;
                    slip_d   = '0;
                    locked_d = 1'b0;
                    error_d  = 1'b0;
                end
                CHECK: begin
                    if (hit) begin
                        if (match_q == MATCH_LAST) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                            loss_d   = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = '0;
                        if (slip_q < SLIP_MAX) begin
                            state_d   = SLIP;
                            bitslip_d = 1'b1;
                            slip_d    = slip_q + 4'd1;
                        end else begin
                            state_d = FAIL;
                            error_d = 1'b1;
                        end
                    end
                end
                SLIP: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d  = CHECK;
                        settle_d = '0;
                        match_d  = '0;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        loss_d = '0;
                    end else if (loss_q == LOSS_LAST) begin
                        state_d  = CHECK;
                        locked_d = 1'b0;
                        loss_d   = '0;
                        match_d  = '0;
                        slip_d   = '0;
                    end else begin
                        loss_d = loss_q + 4'd1;
                    end
                end
                FAIL: begin
                    error_d  = 1'b1;
                    locked_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    error_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            match_q   <= '0;
            settle_q  <= '0;
            loss_q    <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            settle_q  <= settle_d;
            loss_q    <= loss_d;
            slip_q    <= slip_d;
            bitslip_q <= bitslip_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
        end
    end

    assign bitslip_o  = bitslip_q;
    assign locked_o   = locked_q;
    assign error_o    = error_q;
    assign slip_cnt_o = slip_q;

endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// tb/tb_bitslip_align_ctrl.sv - directed bench for bitslip_align_ctrl with a rotating frame-lane model
module tb_bitslip_align_ctrl;

    localparam int SETTLE = 3;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       en;
    logic       realign;
    logic [7:0] frame_i;
    logic       bitslip_o;
    logic       locked_o;
    logic       error_o;
    logic [3:0] slip_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // frame-lane model: each observed bitslip pulse removes one bit of rotation
    logic       use_model;
    logic [7:0] frame_forced;
    int         base_off;
    int         mark;

    int         cyc = 0;
    int         obs_wr = 0;
    int         obs_rd = 0;
    logic [3:0] obs_cnt [64];
    int         obs_cyc [64];
    logic [3:0] exp_q [$];

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [15:0] w;
        w = {v, v} << (n & 7);
        return w[15:8];
    endfunction

    assign frame_i = use_model ? rotl(8'hF0, base_off - (obs_wr - mark)) : frame_forced;

    bitslip_align_ctrl #(
        .PATTERN(8'hF0), .MATCH_COUNT(16), .SETTLE_CYCLES(SETTLE), .MAX_SLIPS(8), .LOSS_THRESH(4)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .en(en), .realign(realign), .frame_i(frame_i),
        .bitslip_o(bitslip_o), .locked_o(locked_o), .error_o(error_o), .slip_cnt_o(slip_cnt_o)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (bitslip_o && obs_wr < 64) begin
            obs_cnt[obs_wr] = slip_cnt_o;
            obs_cyc[obs_wr] = cyc;
            obs_wr = obs_wr + 1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        int last;
        last = -1;
        while (obs_rd < obs_wr) begin
            n_cmp++;
            assert (exp_q.size() > 0) else begin
                n_err++;
                $error("FAIL %s_extra_pulse observed=%0d expected=none", tag, obs_cnt[obs_rd]);
            end
            if (exp_q.size() > 0) chk({tag, "_slip_cnt"}, 8'(obs_cnt[obs_rd]), 8'(exp_q.pop_front()));
            if (last >= 0) begin
                n_cmp++;
                assert (obs_cyc[obs_rd] - last >= SETTLE + 2) else begin
                    n_err++;
                    $error("FAIL %s_spacing observed=%0d expected>=%0d", tag, obs_cyc[obs_rd] - last, SETTLE + 2);
                end
            end
            last = obs_cyc[obs_rd];
            obs_rd++;
        end
        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_missing_pulses observed=%0d expected=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        RST_N = 1'b0; en = 1'b0; realign = 1'b0;
        use_model = 1'b1; frame_forced = 8'h00; base_off = 0; mark = 0;
        #3;
        chk("rst_bitslip", 8'(bitslip_o), 8'h0);
        chk("rst_locked", 8'(locked_o), 8'h0);
        chk("rst_error", 8'(error_o), 8'h0);
        chk("rst_slip_cnt", 8'(slip_cnt_o), 8'h0);
        step();
        RST_N = 1'b1;
        step();

        // pre-aligned lane: lock after exactly 17 cycles, no slips
        en = 1'b1;
        for (int k = 0; k < 16; k++) step();
        chk("prealign_not_yet", 8'(locked_o), 8'h0);
        step();
        chk("prealign_locked", 8'(locked_o), 8'h1);
        chk("prealign_slip_cnt", 8'(slip_cnt_o), 8'h0);
        drain("prealign");

        en = 1'b0;
        step();
        chk("disable_locked", 8'(locked_o), 8'h0);

        // lane offset by three slips
        base_off = 3;
        mark = obs_wr;
        exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
        en = 1'b1;
        for (int k = 0; k < 300 && !locked_o; k++) step();
        chk("offset3_locked", 8'(locked_o), 8'h1);
        chk("offset3_slip_cnt", 8'(slip_cnt_o), 8'h3);
        drain("offset3");

        // loss of lock: three misses then a hit keeps lock
        use_model = 1'b0;
        frame_forced = 8'h00;
        for (int k = 0; k < 3; k++) step();
        chk("loss3_locked", 8'(locked_o), 8'h1);
        frame_forced = 8'hF0;
        step();
        chk("loss_hit_locked", 8'(locked_o), 8'h1);
        frame_forced = 8'h00;
        for (int k = 0; k < 3; k++) step();
        chk("loss3b_locked", 8'(locked_o), 8'h1);
        for (int s = 1; s <= 8; s++) exp_q.push_back(4'(s));
        step();
        chk("loss4_unlocked", 8'(locked_o), 8'h0);
        chk("loss4_slip_clr", 8'(slip_cnt_o), 8'h0);

        // never aligns: eight slips then failure
        for (int k = 0; k < 300 && !error_o; k++) step();
        chk("fail_error", 8'(error_o), 8'h1);
        chk("fail_locked", 8'(locked_o), 8'h0);
        chk("fail_slip_cnt", 8'(slip_cnt_o), 8'h8);
        drain("fail");
        for (int k = 0; k < 10; k++) step();
        chk("fail_hold_error", 8'(error_o), 8'h1);
        chk("fail_hold_cnt", 8'(slip_cnt_o), 8'h8);
        drain("fail_hold");

        exp_q.push_back(4'd1);
        realign = 1'b1;
        step();
        realign = 1'b0;
        chk("realign_error", 8'(error_o), 8'h0);
        chk("realign_slip_cnt", 8'(slip_cnt_o), 8'h0);

        // abort during settle
        for (int k = 0; k < 20 && !bitslip_o; k++) step();
        chk("recheck_pulse", 8'(bitslip_o), 8'h1);
        step();
        en = 1'b0;
        step();
        chk("abort_bitslip", 8'(bitslip_o), 8'h0);
        chk("abort_slip_hold", 8'(slip_cnt_o), 8'h1);
        drain("recheck");
        for (int k = 0; k < 10; k++) step();
        drain("abort_idle");
        en = 1'b1;
        step();
        chk("abort_fresh_cnt", 8'(slip_cnt_o), 8'h0);

        // reset truncates a bitslip pulse without a clock edge
        for (int k = 0; k < 20 && !bitslip_o; k++) step();
        chk("pre_rst_pulse", 8'(bitslip_o), 8'h1);
        RST_N = 1'b0;
        #1;
        chk("rst_slip_bitslip", 8'(bitslip_o), 8'h0);
        chk("rst_slip_cnt", 8'(slip_cnt_o), 8'h0);
        step();
        RST_N = 1'b1;
        drain("rst_slip");

        // reset out of FAIL
        for (int s = 1; s <= 8; s++) exp_q.push_back(4'(s));
        for (int k = 0; k < 300 && !error_o; k++) step();
        chk("fail2_error", 8'(error_o), 8'h1);
        drain("fail2");
        RST_N = 1'b0;
        #1;
        chk("rst_fail_error", 8'(error_o), 8'h0);
        chk("rst_fail_cnt", 8'(slip_cnt_o), 8'h0);
        chk("rst_fail_locked", 8'(locked_o), 8'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
